// File: rtl/loop_replay_sequencer.sv
// loop_replay_sequencer
// Replays a loop body held in the loop buffer BRAM. On a start pulse it walks
// addresses 0..loop_len-1 cyclically and presents each instruction with its
// reconstructed PC to ID over a valid/ready handshake. A 2-entry skid FIFO
// absorbs the one-cycle BRAM latency. Replay ends on mispredict or flush_in.
//
// Optional feature macro: LOOP_REPLAY_ITER_LIMIT_EN
//   Adds input max_iter (sampled with start) and output limit_hit. A nonzero
//   max_iter stops the replay cleanly after that many completed iterations.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start                 replay start pulse (loop_len, loop_pc sampled with it)
//   loop_len, loop_pc     body length incl. closing branch, PC of first entry
//   mispredict, flush_in  abort the replay
//   rd_en, rd_addr        BRAM read port request
//   rd_data               BRAM data, valid one cycle after rd_en
//   out_valid, out_ready  handshake towards ID
//   out_instr, out_pc     replayed instruction and its PC
//   active                high while priming or streaming
//   done                  one-cycle pulse on return to IDLE
//   iter_count            completed iterations of the current/last replay
module loop_replay_sequencer #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   loop_len,
  input  logic [31:0]       loop_pc,
  input  logic              mispredict,
  input  logic              flush_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              active,
  output logic              done,
  output logic [ITER_W-1:0] iter_count
`ifdef LOOP_REPLAY_ITER_LIMIT_EN
  ,
  input  logic [ITER_W-1:0] max_iter,
  output logic              limit_hit
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        last;
  } entry_t;

  state_t state_q, state_d;

  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic [ADDR_W-1:0] rd_idx_q, idx_nxt;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] vld_idx_q;
  logic              vld_last_q;
  entry_t            e0_q, e1_q, e0_d, e1_d, new_e;
  logic              v0_q, v1_q, v0_d, v1_d;
  logic [ITER_W-1:0] iter_q, iter_sat;
  logic              active_q, done_q;

  logic       abort, pop, room, issue, start_go, kill, iter_inc;
  logic       limit_now, issue_stop, len_ok;
  logic [1:0] occ;

  // Handshake, credit and limit terms shared by FSM and datapath
  always_comb begin
    abort    = mispredict | flush_in;
    pop      = v0_q & out_ready;
    len_ok   = (loop_len != '0) && (loop_len <= LEN_W'(DEPTH));
    // Occupancy after this cycle's pop plus data already on the BRAM bus;
    // counting the pop lets a freed slot be refilled in the same cycle.
    occ      = 2'(v0_q) + 2'(v1_q) - 2'(pop);
    room     = (occ + 2'(rd_vld_q)) < 2'd2;
    iter_sat = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
    iter_inc = pop & e0_q.last & ~abort;
    idx_nxt  = (rd_idx_q == last_idx_q) ? '0 : rd_idx_q + ADDR_W'(1);
  end

`ifdef LOOP_REPLAY_ITER_LIMIT_EN
  logic [ITER_W-1:0] max_q, issue_iter_q;
  logic              limit_hit_q;

  // Reads stop once the final entry of the last allowed iteration is issued,
  // so the FIFO drains exactly to the limit with nothing extra in flight.
  always_comb begin
    issue_stop = (max_q != '0) && (issue_iter_q == max_q);
    limit_now  = (max_q != '0) && iter_inc && (iter_sat == max_q);
  end
`else
  always_comb begin
    issue_stop = 1'b0;
    limit_now  = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and read issue
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort && start && len_ok) state_d = PRIME;
      end
      PRIME, STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          issue   = room & ~issue_stop;
          state_d = limit_now ? IDLE : STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_go = (state_q == IDLE) && (state_d == PRIME);
    kill     = (state_d == IDLE);
  end

  // Skid FIFO: slot 0 is always the head so outputs come straight from flops
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    new_e = '{instr: rd_data,
              pc:    pc_q + 32'({vld_idx_q, 2'b00}),
              last:  vld_last_q};
    if (pop) begin
      e0_d = e1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
    end
    if (rd_vld_q) begin
      if (!v0_d) begin
        e0_d = new_e;
        v0_d = 1'b1;
      end else begin
        e1_d = new_e;
        v1_d = 1'b1;
      end
    end
    if (kill) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      last_idx_q <= '0;
      rd_idx_q   <= '0;
      rd_vld_q   <= 1'b0;
      vld_idx_q  <= '0;
      vld_last_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      iter_q     <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      active_q   <= (state_d != IDLE);
      done_q     <= (state_q != IDLE) && (state_d == IDLE);
      rd_vld_q   <= issue;
      vld_idx_q  <= rd_idx_q;
      vld_last_q <= (rd_idx_q == last_idx_q);
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      if (start_go) begin
        pc_q       <= loop_pc;
        last_idx_q <= ADDR_W'(loop_len - LEN_W'(1));
      end
      if (start_go)   rd_idx_q <= '0;
      else if (issue) rd_idx_q <= idx_nxt;
      if (start_go)      iter_q <= '0;
      else if (iter_inc) iter_q <= iter_sat;
    end
  end

`ifdef LOOP_REPLAY_ITER_LIMIT_EN
  // Iteration limit tracking on the issue side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q        <= '0;
      issue_iter_q <= '0;
      limit_hit_q  <= 1'b0;
    end else begin
      limit_hit_q <= (state_q != IDLE) && limit_now && !abort;
      if (start_go) begin
        max_q        <= max_iter;
        issue_iter_q <= '0;
      end else if (issue && (rd_idx_q == last_idx_q) && (issue_iter_q != '1)) begin
        issue_iter_q <= issue_iter_q + ITER_W'(1);
      end
    end
  end

  assign limit_hit = limit_hit_q;
`endif

  assign rd_en      = issue;
  assign rd_addr    = rd_idx_q;
  assign out_valid  = v0_q;
  assign out_instr  = e0_q.instr;
  assign out_pc     = e0_q.pc;
  assign active     = active_q;
  assign done       = done_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_loop_replay_sequencer.sv
// Scoreboard bench for loop_replay_sequencer: stimulus pushes expected
// {instr, pc} pairs, a negedge monitor pops and compares on every accept.
module tb_loop_replay_sequencer;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned ITER_W = 16;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   loop_len;
  logic [31:0]       loop_pc;
  logic              mispredict;
  logic              flush_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              active;
  logic              done;
  logic [ITER_W-1:0] iter_count;
`ifdef LOOP_REPLAY_ITER_LIMIT_EN
  logic [ITER_W-1:0] max_iter;
  logic              limit_hit;
`endif

  loop_replay_sequencer #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .loop_len   (loop_len),
    .loop_pc    (loop_pc),
    .mispredict (mispredict),
    .flush_in   (flush_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .active     (active),
    .done       (done),
    .iter_count (iter_count)
`ifdef LOOP_REPLAY_ITER_LIMIT_EN
    ,
    .max_iter   (max_iter),
    .limit_hit  (limit_hit)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  logic [63:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cnt  = 0;
  logic        rd_seen  = 1'b0;
  logic        chk_stable = 1'b0;
  logic [63:0] hold;

  function automatic logic [31:0] mem_val(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // BRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output and check hold stability
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) rd_seen = 1'b1;
      if (chk_stable) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", {out_instr, out_pc}, hold);
      end
      chk_stable = out_valid && !out_ready && !(mispredict || flush_in);
      hold = {out_instr, out_pc};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", {out_instr, out_pc});
        end else begin
          chk("stream", {out_instr, out_pc}, exp_q.pop_front());
        end
        acc_cnt++;
      end
    end else begin
      chk_stable = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int len, input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      int idx = i % len;
      exp_q.push_back({mem_val(idx), pc + 32'(idx * 4)});
    end
  endtask

  task automatic do_start(input int len, input logic [31:0] pc);
    start    = 1'b1;
    loop_len = (ADDR_W+1)'(len);
    loop_pc  = pc;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_acc(input int base, input int n, input int budget, input string name);
    int k = 0;
    while ((acc_cnt - base) < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(acc_cnt - base), 64'(n));
  endtask

  task automatic do_abort(input logic use_flush);
    out_ready = 1'b0;
    if (use_flush) flush_in = 1'b1;
    else           mispredict = 1'b1;
    tick();
    flush_in   = 1'b0;
    mispredict = 1'b0;
    tick();
    exp_q.delete();
  endtask

  int base;
  int got;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = mem_val(i);
    reset = 1'b0; start = 1'b0; loop_len = '0; loop_pc = '0;
    mispredict = 1'b0; flush_in = 1'b0; out_ready = 1'b0;
`ifdef LOOP_REPLAY_ITER_LIMIT_EN
    max_iter = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en",     64'(rd_en),      64'd0);
    chk("rst_rd_addr",   64'(rd_addr),    64'd0);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_out_instr", 64'(out_instr),  64'd0);
    chk("rst_out_pc",    64'(out_pc),     64'd0);
    chk("rst_active",    64'(active),     64'd0);
    chk("rst_done",      64'(done),       64'd0);
    chk("rst_iter",      64'(iter_count), 64'd0);
    reset = 1'b1;
    tick();

    // T1: len 4 at 0x100, ready held high
    base = acc_cnt;
    push_exp(4, 32'h100, 12);
    out_ready = 1'b1;
    do_start(4, 32'h100);
    tick();
    chk("t1_lat_early", 64'(out_valid), 64'd0);
    chk("t1_active",    64'(active),    64'd1);
    tick();
    chk("t1_lat_first", 64'(out_valid), 64'd1);
    wait_acc(base, 4, 50, "t1_acc4");
    chk("t1_iter1", 64'(iter_count), 64'd1);
    wait_acc(base, 12, 50, "t1_acc12");
    out_ready = 1'b0;
    chk("t1_iter3", 64'(iter_count), 64'd3);

    // T3: mispredict with two entries buffered
    repeat (3) tick();
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t3_buffered", 64'(out_valid), 64'd1);
    mispredict = 1'b1;
    tick();
    mispredict = 1'b0;
    chk("t3_valid", 64'(out_valid),  64'd0);
    chk("t3_done",  64'(done),       64'd1);
    chk("t3_idle",  64'(active),     64'd0);
    chk("t3_iter",  64'(iter_count), 64'd3);
    tick();
    chk("t3_done_pulse", 64'(done), 64'd0);
    base = acc_cnt;
    push_exp(4, 32'h100, 4);
    out_ready = 1'b1;
    do_start(4, 32'h100);
    wait_acc(base, 4, 50, "t3_restart_acc");
    out_ready = 1'b0;
    chk("t3_restart_iter", 64'(iter_count), 64'd1);
    do_abort(1'b1);

    // T2: pseudo-random out_ready for 200 cycles
    base = acc_cnt;
    push_exp(4, 32'h100, 210);
    start = 1'b1; loop_len = 7'd4; loop_pc = 32'h100;
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
    end
    out_ready = 1'b0;
    tick();
    got = acc_cnt - base;
    chk("t2_progress", 64'(got > 40), 64'd1);
    chk("t2_iter", 64'(iter_count), 64'(got / 4));
    do_abort(1'b0);

    // T4: loop_len 1 and loop_len DEPTH (PC wraps past 2**32)
    base = acc_cnt;
    push_exp(1, 32'h2000, 6);
    out_ready = 1'b1;
    do_start(1, 32'h2000);
    wait_acc(base, 6, 50, "t4_len1_acc");
    out_ready = 1'b0;
    chk("t4_len1_iter", 64'(iter_count), 64'd6);
    do_abort(1'b1);
    base = acc_cnt;
    push_exp(DEPTH, 32'hFFFF_FFF0, 70);
    out_ready = 1'b1;
    do_start(DEPTH, 32'hFFFF_FFF0);
    wait_acc(base, 70, 200, "t4_full_acc");
    out_ready = 1'b0;
    chk("t4_full_iter", 64'(iter_count), 64'd1);
    do_abort(1'b0);
    for (int k = 0; k < 2; k++) begin
      rd_seen = 1'b0;
      out_ready = 1'b1;
      do_start((k == 0) ? 0 : DEPTH + 1, 32'h500);
      repeat (4) tick();
      chk("t4_badlen_active", 64'(active),    64'd0);
      chk("t4_badlen_rd",     64'(rd_seen),   64'd0);
      chk("t4_badlen_valid",  64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

    // T5: start with flush in the same cycle, then async reset mid-replay
    rd_seen = 1'b0;
    flush_in = 1'b1;
    do_start(3, 32'h300);
    flush_in = 1'b0;
    chk("t5_idle",   64'(active), 64'd0);
    chk("t5_nodone", 64'(done),   64'd0);
    tick();
    chk("t5_nodone2", 64'(done),    64'd0);
    chk("t5_nord",    64'(rd_seen), 64'd0);
    base = acc_cnt;
    push_exp(3, 32'h300, 3);
    out_ready = 1'b1;
    do_start(3, 32'h300);
    wait_acc(base, 3, 50, "t5_acc");
    out_ready = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_rd_en",  64'(rd_en),      64'd0);
    chk("t5_rst_addr",   64'(rd_addr),    64'd0);
    chk("t5_rst_valid",  64'(out_valid),  64'd0);
    chk("t5_rst_instr",  64'(out_instr),  64'd0);
    chk("t5_rst_pc",     64'(out_pc),     64'd0);
    chk("t5_rst_active", 64'(active),     64'd0);
    chk("t5_rst_iter",   64'(iter_count), 64'd0);
    #2 reset = 1'b1;
    tick();
    chk("t5_rst_nodone", 64'(done), 64'd0);
    exp_q.delete();

`ifdef LOOP_REPLAY_ITER_LIMIT_EN
    // T6: max_iter 3 on a 5-entry loop
    begin
      int k = 0;
      base = acc_cnt;
      push_exp(5, 32'h400, 15);
      max_iter = 16'd3;
      out_ready = 1'b1;
      do_start(5, 32'h400);
      while (!done && k < 200) begin
        tick();
        k++;
      end
      chk("t6_done",      64'(done),          64'd1);
      chk("t6_limit_hit", 64'(limit_hit),     64'd1);
      chk("t6_accepts",   64'(acc_cnt - base), 64'd15);
      tick();
      chk("t6_done_pulse",  64'(done),      64'd0);
      chk("t6_limit_pulse", 64'(limit_hit), 64'd0);
      chk("t6_idle",        64'(active),    64'd0);
      repeat (5) tick();
      chk("t6_no_extra", 64'(acc_cnt - base), 64'd15);
      out_ready = 1'b0;
      max_iter = '0;
    end
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
